i2s_master_tx: RTL

- I2S transmitter that is the bus master: generates BCLK and LRCLK from the system clock and serializes stereo samples MSB-first.
- Drives an external DAC or codec configured as I2S slave. Complements the existing codec-mastered i2s_rx/i2s_tx path.
- Fed from the effects chain through a valid/ready handshake in the clk domain. Single clock domain, so no CDC FIFO is needed.

---
 rtl/i2s_pkg.sv | 13 +
 rtl/i2s_bclk_gen.sv | 58 +++++
 rtl/i2s_master_tx.sv | 108 ++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared constants for the clk-mastered I2S transmit path.
package i2s_pkg;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_SLOT_WIDTH = 32;
    localparam int DEF_BCLK_DIV   = 4;

    localparam int UNDERRUN_CNT_W = 16;

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK divider and slot bit counter; flags the clk cycle in which BCLK falls
// and a new bit (and possibly a new frame) begins.
module i2s_bclk_gen
    import i2s_pkg::*;
#(
    parameter int SLOT_WIDTH = DEF_SLOT_WIDTH,
    parameter int BCLK_DIV   = DEF_BCLK_DIV,
    localparam int CNT_W     = $clog2(2 * SLOT_WIDTH),
    localparam int DIV_W     = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    output logic             bclk,
    output logic             lrclk,
    output logic             fall_tick,
    output logic             frame_tick,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] cur_bit;
    logic             div_term;

    // bit_cnt is the index the current falling edge moves into, so the
    // serializer can register the matching sdata in the same cycle.
    assign div_term   = (div_cnt == DIV_LAST);
    assign fall_tick  = enable && div_term && bclk;
    assign bit_cnt    = (cur_bit == LAST_BIT) ? '0 : cur_bit + CNT_W'(1);
    assign frame_tick = fall_tick && (bit_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bclk    <= 1'b1;
            lrclk   <= LR_RIGHT;
            cur_bit <= LAST_BIT;
        end else if (!enable) begin
            div_cnt <= '0;
            bclk    <= 1'b1;
            lrclk   <= LR_RIGHT;
            cur_bit <= LAST_BIT;
        end else if (div_term) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
            if (bclk) begin
                cur_bit <= bit_cnt;
                lrclk   <= (bit_cnt >= CNT_W'(SLOT_WIDTH)) ? LR_RIGHT : LR_LEFT;
            end
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/i2s_master_tx.sv
// I2S bus-master transmitter: one-word holding register fed by valid/ready,
// frame register loaded at each frame start, MSB-first serializer.
module i2s_master_tx
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SLOT_WIDTH = DEF_SLOT_WIDTH,
    parameter int BCLK_DIV   = DEF_BCLK_DIV
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_WIDTH-1:0]     s_data,
    output logic                      bclk,
    output logic                      lrclk,
    output logic                      sdata,
    output logic                      frame_start,
    output logic                      underrun,
    output logic [UNDERRUN_CNT_W-1:0] underrun_count
);

    localparam int HALF  = DATA_WIDTH / 2;
    localparam int CNT_W = $clog2(2 * SLOT_WIDTH);

    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [DATA_WIDTH-1:0] frame_reg;
    logic                  fall_tick;
    logic                  frame_tick;
    logic [CNT_W-1:0]      next_bit;
    logic                  accept;

    // Slot position 0 is the one-BCLK I2S delay; positions past the channel
    // width pad the slot with zeros.
    function automatic logic serial_bit(input logic [DATA_WIDTH-1:0] word,
                                        input logic [CNT_W-1:0]      k);
        int unsigned kk;
        int unsigned p;
        logic        right;
        kk    = 32'(k);
        right = (kk >= SLOT_WIDTH);
        p     = right ? kk - SLOT_WIDTH : kk;
        serial_bit = 1'b0;
        if (p >= 1 && p <= HALF) begin
            serial_bit = right ? 1'(word >> (HALF - p)) : 1'(word >> (DATA_WIDTH - p));
        end
    endfunction

    function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(input logic [UNDERRUN_CNT_W-1:0] v);
        return (&v) ? v : v + UNDERRUN_CNT_W'(1);
    endfunction

    i2s_bclk_gen #(
        .SLOT_WIDTH (SLOT_WIDTH),
        .BCLK_DIV   (BCLK_DIV)
    ) u_bclk_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .fall_tick  (fall_tick),
        .frame_tick (frame_tick),
        .bit_cnt    (next_bit)
    );

    assign s_ready = ~hold_valid;
    assign accept  = s_valid && !hold_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid     <= 1'b0;
            sdata          <= 1'b0;
            frame_start    <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            frame_start <= frame_tick;
            underrun    <= frame_tick && !hold_valid;
            // A word accepted on an empty-register frame start waits for the next frame.
            if (accept) begin
                hold_valid <= 1'b1;
            end else if (frame_tick) begin
                hold_valid <= 1'b0;
            end
            if (frame_tick && !hold_valid) begin
                underrun_count <= sat_inc(underrun_count);
            end
            if (!enable) begin
                sdata <= 1'b0;
            end else if (fall_tick) begin
                sdata <= serial_bit(frame_reg, next_bit);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            hold_data <= s_data;
        end
        if (frame_tick) begin
            frame_reg <= hold_valid ? hold_data : '0;
        end
    end

endmodule
